regfile_mp: RTL
===============

// Module: regfile_mp
// PURPOSE
//   Parametrised multi-port register file for the MIPS datapath; next generation of the 2R/1W file.
//   Configurable width, depth and read/write port counts; register 0 optionally hardwired to zero.
//   Adds write-to-read bypass, deterministic multi-write priority with conflict flag, and a
//   sequential clear engine. Sits in decode (reads) and writeback (writes).
// PARAMETERS
//   DATA_W   32  register width in bits
//   ADDR_W   5   address width; DEPTH = 2**ADDR_W registers
//   NUM_RD   2   number of combinational read ports (>=1)
//   NUM_WR   2   number of write ports (>=1)
//   ZERO_REG 1   1: reg 0 reads 0 and ignores writes; 0: reg 0 is ordinary
//   BYPASS   1   1: a read returns same-cycle write data; 0: the read returns the stored value
// PORTS
//   clk          in   1               rising-edge clock
//   rst_n        in   1               asynchronous active-low reset
//   rd_addr      in   NUM_RD*ADDR_W   read addresses; port k = [k*ADDR_W +: ADDR_W]
//   rd_data      out  NUM_RD*DATA_W   read data; port k = [k*DATA_W +: DATA_W]
//   wr_en        in   NUM_WR          per-port write enable
//   wr_addr      in   NUM_WR*ADDR_W   write addresses, packed as rd_addr
//   wr_data      in   NUM_WR*DATA_W   write data, packed as rd_data
//   clr_req      in   1               start the sequential clear (sampled in IDLE only)
//   clr_busy     out  1               clear in progress
//   clr_done     out  1               one-cycle pulse when the clear completes
//   wr_conflict  out  1               registered flag: >=2 enabled writes hit the same address
// BEHAVIOUR
//   Reset (rst_n=0, async): all registers 0; FSM=IDLE; clr_cnt=0; clr_busy=0; clr_done=0; wr_conflict=0.
//   Reads: combinational, 0-cycle latency.
//     - ZERO_REG=1 and addr==0 -> 0.
//     - clr_busy=1 -> 0 for every port.
//     - BYPASS=1 and an enabled write targets addr -> that write's data (highest-index port wins).
//     - Otherwise -> the stored value.
//   Writes: committed on the rising edge when wr_en[j]=1 and the FSM is IDLE or DONE.
//     - Same address on several ports: the highest-index port wins.
//     - Writes to reg 0 are discarded when ZERO_REG=1.
//   wr_conflict: registered, high in the cycle after an edge where >=2 enabled ports shared an address.
//     - Computed on raw wr_en/wr_addr, so it also flags address 0 and writes dropped during CLEAR.
//     - Otherwise 0.
//   Clear FSM: IDLE -> CLEAR -> DONE -> IDLE.
//     - IDLE: clr_req=1 at an edge -> CLEAR with clr_cnt=0.
//     - CLEAR: each edge writes reg[clr_cnt]=0 and increments clr_cnt.
//       At clr_cnt==DEPTH-1 the reg is zeroed, clr_cnt wraps to 0 and the FSM goes to DONE.
//     - DONE: clr_done=1 for exactly one cycle, then IDLE.
//     - clr_busy=1 only in CLEAR, i.e. exactly DEPTH cycles.
//   Boundary rules:
//     - clr_req while CLEAR or DONE is ignored (no restart, no queueing).
//     - Port writes during CLEAR are dropped, including on the final CLEAR cycle.
//     - A port write in the DONE cycle commits normally.
//     - Reset mid-clear aborts immediately: FSM=IDLE and all regs 0.
//     - clr_cnt is ADDR_W+1 bits internally so the DEPTH-1 compare cannot alias.
// TESTING
//   1 Reset: assert rst_n=0 mid-cycle -> all rd_data=0, clr_busy=0, clr_done=0, wr_conflict=0 immediately.
//   2 Write/read: wr_en=01, addr 5, data 0xDEADBEEF; next cycle rd_addr0=5 -> 0xDEADBEEF.
//     Then write 0x1234 to reg 0 -> reads 0.
//   3 Bypass: BYPASS=1, write addr 7 = 0xA5A5A5A5 while rd_addr1=7 -> same-cycle rd_data1=0xA5A5A5A5.
//     With BYPASS=0 -> the old value.
//   4 Conflict: ports 0 and 1 write addr 3 with 0x11 and 0x22 -> reg 3 = 0x22, wr_conflict=1 for one cycle.
//     Ports 0 and 1 write addr 0 -> wr_conflict=1 for one cycle.
//   5 Clear: fill regs 1..31 with the index value, pulse clr_req -> clr_busy high 32 cycles, reads 0 throughout.
//     A port-0 write to addr 9 during CLEAR is dropped. clr_done pulses once. All regs then 0.
//     A second clr_req during CLEAR has no effect.
//   6 Abort: pulse clr_req, assert rst_n=0 after 10 cycles -> FSM IDLE, clr_busy=0.
//     After release, write/read works and a new clear takes the full 32 cycles.

Source files
------------

// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, write ports,
// clear handshake and status flags. The master drives addresses, write data
// and clr_req. The slave is the register file itself.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;
    logic                     wr_conflict;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, clr_busy, clr_done, wr_conflict
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, clr_busy, clr_done, wr_conflict
    );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with same-cycle write bypass,
// highest-index-wins write priority, a registered multi-write conflict flag
// and a sequential clear engine (IDLE -> CLEAR -> DONE -> IDLE).
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    // One extra bit so the last-index compare never aliases with a wrapped count.
    localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W:0]   clr_cnt;
    logic [DATA_W-1:0] regs [DEPTH];
    logic              conflict_q;
    logic              conflict_w;
    logic              clr_busy_w;
    logic              wr_open;

    assign clr_busy_w      = (state == ST_CLEAR);
    assign wr_open         = (state == ST_IDLE) || (state == ST_DONE);
    assign bus.clr_busy    = clr_busy_w;
    assign bus.clr_done    = (state == ST_DONE);
    assign bus.wr_conflict = conflict_q;

    // Clear sequencer: walks clr_cnt over every register, then one DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt == CNT_LAST) begin
                        state   <= ST_DONE;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage: clear engine owns the array during CLEAR; otherwise port writes,
    // later ports overriding earlier ones on a shared address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (clr_busy_w) begin
            regs[clr_cnt[ADDR_W-1:0]] <= '0;
        end else if (wr_open) begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (bus.wr_en[j] &&
                    !((ZERO_REG != 0) && (bus.wr_addr[j*ADDR_W +: ADDR_W] == '0))) begin
                    regs[bus.wr_addr[j*ADDR_W +: ADDR_W]] <= bus.wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Conflict detect on raw enables/addresses, independent of FSM state.
    always_comb begin
        conflict_w = 1'b0;
        for (int i = 1; i < NUM_WR; i++) begin
            for (int j = 0; j < i; j++) begin
                if (bus.wr_en[i] && bus.wr_en[j] &&
                    (bus.wr_addr[i*ADDR_W +: ADDR_W] == bus.wr_addr[j*ADDR_W +: ADDR_W])) begin
                    conflict_w = 1'b1;
                end
            end
        end
    end

    // Registered conflict flag, high for the cycle after the offending edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) conflict_q <= 1'b0;
        else        conflict_q <= conflict_w;
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] word;

        assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

        // Read mux: stored value, overridden by bypass, forced to zero by clear or reg 0.
        always_comb begin
            word = regs[ra];
            if (BYPASS != 0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.wr_en[j] && (bus.wr_addr[j*ADDR_W +: ADDR_W] == ra)) begin
                        word = bus.wr_data[j*DATA_W +: DATA_W];
                    end
                end
            end
            if (clr_busy_w || ((ZERO_REG != 0) && (ra == '0))) word = '0;
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = word;
    end
endmodule
